// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states, NOP encoding,
// stop opcode and the address width.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [31:0] NOP_INST    = 32'h0000_0000;
  localparam logic [5:0]  STOP_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> decode / instruction-memory signal bundle.
// The slave modport is the fetch unit; the master modport is decode + imem.
// Optional FETCH_PERF_EN adds the perf_cycles / perf_stalls counters.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              stall;
  logic              d_rst;
  logic              pc_jump;
  logic              pc_jr;
  logic              pc_branch;
  logic [25:0]       jump_index;
  logic [ADDR_W-1:0] jr_target;
  logic [31:0]       branch_offset;
  logic              is_display;
  logic [31:0]       inst_rdata;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       d_inst;
  logic [ADDR_W-1:0] d_pc_plus4;
  logic              d_valid;
  logic              halted;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_stalls;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    input  perf_cycles,
    input  perf_stalls,
`endif
    output stall,
    output d_rst,
    output pc_jump,
    output pc_jr,
    output pc_branch,
    output jump_index,
    output jr_target,
    output branch_offset,
    output is_display,
    output inst_rdata,
    input  imem_addr,
    input  d_inst,
    input  d_pc_plus4,
    input  d_valid,
    input  halted
  );

  modport slave (
`ifdef FETCH_PERF_EN
    output perf_cycles,
    output perf_stalls,
`endif
    input  stall,
    input  d_rst,
    input  pc_jump,
    input  pc_jr,
    input  pc_branch,
    input  jump_index,
    input  jr_target,
    input  branch_offset,
    input  is_display,
    input  inst_rdata,
    output imem_addr,
    output d_inst,
    output d_pc_plus4,
    output d_valid,
    output halted
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Redirect target computation for the fetch stage.
// Priority jr > branch > jump; branch/jump are relative to the PC+4 held in IF/ID.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic              i_pc_jump,
  input  logic              i_pc_jr,
  input  logic              i_pc_branch,
  input  logic [25:0]       i_jump_index,
  input  logic [ADDR_W-1:0] i_jr_target,
  input  logic [31:0]       i_branch_offset,
  input  logic [ADDR_W-1:0] i_d_pc_plus4,
  output logic              o_redirect,
  output logic [ADDR_W-1:0] o_target
);

  logic [ADDR_W-1:0] w_branch_target;
  logic [ADDR_W-1:0] w_jump_target;

  assign w_branch_target = i_d_pc_plus4 + (i_branch_offset << 2);
  assign w_jump_target   = {i_d_pc_plus4[31:28], i_jump_index, 2'b00};

  // Select the highest-priority redirect target.
  always_comb begin
    o_redirect = i_pc_jr | i_pc_branch | i_pc_jump;
    o_target   = '0;
    if (i_pc_jr) begin
      o_target = i_jr_target;
    end else if (i_pc_branch) begin
      o_target = w_branch_target;
    end else if (i_pc_jump) begin
      o_target = w_jump_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage + IF/ID register with halt/drain sequencing.
// Owns the PC; applies decode redirects one cycle after decode; on the stop
// opcode drains for DRAIN_CYCLES cycles then raises halted until reset.
// Optional feature macro: FETCH_PERF_EN (perf_cycles / perf_stalls counters).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned       DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [31:0]       r_inst, w_inst_nxt;
  logic [ADDR_W-1:0] r_pc4, w_pc4_nxt;
  logic              r_valid, w_valid_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .i_pc_jump       (bus.pc_jump),
    .i_pc_jr         (bus.pc_jr),
    .i_pc_branch     (bus.pc_branch),
    .i_jump_index    (bus.jump_index),
    .i_jr_target     (bus.jr_target),
    .i_branch_offset (bus.branch_offset),
    .i_d_pc_plus4    (r_pc4),
    .o_redirect      (w_redirect),
    .o_target        (w_target)
  );

  // Next-state, next-PC and IF/ID contents; everything holds by default.
  // A redirect without d_rst still latches the fetched slot; d_rst alone
  // kills it while the PC keeps advancing sequentially.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (!bus.stall) begin
          if (bus.is_display) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = '0;
            w_inst_nxt  = NOP_INST;
            w_valid_nxt = 1'b0;
          end else begin
            w_pc_nxt = w_redirect ? w_target : w_pc_plus4;
            if (bus.d_rst) begin
              w_inst_nxt  = NOP_INST;
              w_valid_nxt = 1'b0;
            end else begin
              w_inst_nxt  = bus.inst_rdata;
              w_pc4_nxt   = w_pc_plus4;
              w_valid_nxt = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.d_inst     = r_inst;
  assign bus.d_pc_plus4 = r_pc4;
  assign bus.d_valid    = r_valid;
  assign bus.halted     = (r_state == HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  // Saturating activity counters; both freeze once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if ((r_state != HALT) && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == RUN) && bus.stall && (r_perf_stalls != '1)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a directed prologue following the test plan,
// then randomized decode-control traffic checked against a behavioural model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          DC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC     (RPC),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
  endfunction

  always_comb bus.inst_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] pcyc;
    logic [31:0] pstl;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cycle  = 0;

  // Reference model: architectural view of PC and IF/ID; halting is tracked
  // as "cycles left until halted" (-1 = running, 0 = halted).
  logic [31:0] m_pc, m_inst, m_pc4, m_cyc, m_stl;
  logic        m_valid;
  int          m_left;

  task automatic step(input bit r, input bit st, input bit dr, input bit dsp,
                      input bit jr, input bit br, input bit jp,
                      input logic [25:0] idx, input logic [31:0] jt,
                      input logic [31:0] off);
    logic [31:0] nxt;
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.stall         = st;
    bus.d_rst         = dr;
    bus.is_display    = dsp;
    bus.pc_jr         = jr;
    bus.pc_branch     = br;
    bus.pc_jump       = jp;
    bus.jump_index    = idx;
    bus.jr_target     = jt;
    bus.branch_offset = off;
    if (r) begin
      m_pc = RPC; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_left = -1; m_cyc = 32'h0; m_stl = 32'h0;
    end else begin
      if (m_left != 0 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (m_left < 0 && st && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
      if (m_left == 0) begin
        // halted: nothing changes
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (st) begin
        // stalled: hold everything
      end else if (dsp) begin
        m_left  = DC;
        m_inst  = 32'h0;
        m_valid = 1'b0;
      end else begin
        if (jr)      nxt = jt;
        else if (br) nxt = m_pc4 + off * 4;
        else if (jp) nxt = (m_pc4 & 32'hF000_0000) | ({6'b0, idx} * 4);
        else         nxt = m_pc + 4;
        if (dr) begin
          m_inst  = 32'h0;
          m_valid = 1'b0;
        end else begin
          m_inst  = mem_word(m_pc);
          m_pc4   = m_pc + 4;
          m_valid = 1'b1;
        end
        m_pc = nxt;
      end
    end
    e.addr = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid;
    e.halted = (m_left == 0); e.pcyc = m_cyc; e.pstl = m_stl;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
  endtask

  task automatic do_jr(input logic [31:0] t);
    step(0, 0, 1, 0, 1, 0, 0, 26'h0, t, 32'h0);
  endtask

  // Monitor: one scoreboard entry per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.imem_addr !== e.addr || bus.d_inst !== e.inst ||
            bus.d_pc_plus4 !== e.pc4 || bus.d_valid !== e.valid ||
            bus.halted !== e.halted) begin
          failed++;
          $display("FAIL fetch_state cyc=%0d got addr=%h inst=%h pc4=%h v=%b h=%b required addr=%h inst=%h pc4=%h v=%b h=%b",
                   cycle, bus.imem_addr, bus.d_inst, bus.d_pc_plus4, bus.d_valid, bus.halted,
                   e.addr, e.inst, e.pc4, e.valid, e.halted);
        end
`ifdef FETCH_PERF_EN
        tests++;
        if (bus.perf_cycles !== e.pcyc || bus.perf_stalls !== e.pstl) begin
          failed++;
          $display("FAIL perf_counters cyc=%0d got cycles=%0d stalls=%0d required cycles=%0d stalls=%0d",
                   cycle, bus.perf_cycles, bus.perf_stalls, e.pcyc, e.pstl);
        end
`endif
      end
    end
  end

  initial begin
    bit r, st, dr, dsp, jr, br, jp;
    logic [25:0] idx;
    logic [31:0] jt, off;
    int wait_cnt;

    bus.stall = 0; bus.d_rst = 0; bus.is_display = 0;
    bus.pc_jr = 0; bus.pc_branch = 0; bus.pc_jump = 0;
    bus.jump_index = '0; bus.jr_target = '0; bus.branch_offset = '0;

    // Reset then sequential fetch from RESET_PC.
    step(1, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(3);
    // Branch from d_pc_plus4=0x20 with offset -2 -> 0x18.
    do_jr(32'h0000_001C);
    idle(1);
    step(0, 0, 1, 0, 0, 1, 0, 26'h0, 32'h0, 32'hFFFF_FFFE);
    idle(2);
    // jr and jump together: jr wins.
    step(0, 0, 1, 0, 1, 0, 1, 26'h3, 32'h0000_0400, 32'h0);
    idle(1);
    // Jump keeps upper nibble of d_pc_plus4=0xF000_0010.
    do_jr(32'hF000_000C);
    idle(1);
    step(0, 0, 1, 0, 0, 0, 1, 26'h3, 32'h0, 32'h0);
    idle(2);
    // Three stalled cycles with a jump select present: ignored.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 1, 26'h155, 32'h0, 32'h0);
    idle(1);
    // PC wraparound past 0xFFFF_FFFC.
    do_jr(32'hFFFF_FFFC);
    idle(2);
    // Stall and display together: stall wins, display taken next cycle.
    step(0, 1, 0, 1, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(7);
    // Reset in the middle of draining.
    step(1, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(3);
    // Five RUN cycles with two stalls.
    step(1, 0, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(1); step(0, 1, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(1); step(0, 1, 0, 0, 0, 0, 0, 26'h0, 32'h0, 32'h0);
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 199) == 0) || (m_left == 0 && $urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 4) == 0);
      dsp = ($urandom_range(0, 59) == 0);
      jr = 0; br = 0; jp = 0;
      if ($urandom_range(0, 99) < 15) begin
        {jr, br, jp} = 3'($urandom_range(1, 7));
        dr = ($urandom_range(0, 7) != 0);
      end else begin
        dr = ($urandom_range(0, 19) == 0);
      end
      idx = 26'($urandom);
      jt  = $urandom & 32'hFFFF_FFFC;
      off = 32'($urandom_range(0, 64)) - 32'd32;
      step(r, st, dr, dsp, jr, br, jp, idx, jt, off);
    end

    wait_cnt = 0;
    while (q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
